// File: rtl/accumulator_exec_unit.sv
// accumulator_exec_unit
//   Execute stage of the 8-bit accumulator CPU. Accepts one decoded
//   instruction per valid/ready handshake, reads the operand from the
//   register file, applies the ALU operation to the internal accumulator
//   and, for STA, writes the accumulator back to the register file.
//   One instruction per three cycles: IDLE (accept) -> READ -> EXEC.
//
// Ports
//   clk, reset (async, active-low)
//   instr_valid / instr_ready     : instruction handshake
//   opcode, reg_sel, imm          : decoded instruction fields
//   rf_read_addr / rf_read_data   : register file read port (comb read)
//   rf_write_addr/_data/_en       : register file write port
//   acc_out, carry_flag, zero_flag: architectural state
//   done, illegal_op              : one-cycle retire pulses
module accumulator_exec_unit #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] reg_sel,
  input  logic [DATA_W-1:0]     imm,
  output logic [REG_ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0]     rf_read_data,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic                  rf_write_en,
  output logic [DATA_W-1:0]     acc_out,
  output logic                  carry_flag,
  output logic                  zero_flag,
  output logic                  done,
  output logic                  illegal_op
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA,
    OP_ADC = 4'hB
  } op_t;

  state_t                  state, state_nxt;
  logic [3:0]              op_q;
  logic [REG_ADDR_W-1:0]   reg_q;
  logic [DATA_W-1:0]       imm_q;
  logic [DATA_W-1:0]       operand_q;
  logic [DATA_W-1:0]       acc_q, acc_nxt;
  logic                    carry_q, carry_nxt;
  logic                    op_legal;
  logic [DATA_W:0]         sum;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Opcodes 0xC..0xF are the only illegal encodings.
  always_comb begin
    op_legal = (op_q <= OP_ADC);
  end

  // Output logic
  always_comb begin
    instr_ready = (state == IDLE);
    done        = (state == EXEC);
    illegal_op  = (state == EXEC) && !op_legal;
    rf_write_en = (state == EXEC) && (op_q == OP_STA);
  end

  assign rf_read_addr  = reg_q;
  assign rf_write_addr = reg_q;
  assign rf_write_data = acc_q;
  assign acc_out       = acc_q;
  assign carry_flag    = carry_q;
  assign zero_flag     = (acc_q == '0);

  // ALU: next accumulator/carry computed from the latched instruction
  // and the operand captured in READ. Illegal opcodes fall to the default.
  always_comb begin
    acc_nxt   = acc_q;
    carry_nxt = carry_q;
    sum       = '0;
    case (op_q)
      OP_LDI: acc_nxt = imm_q;
      OP_LDA: acc_nxt = operand_q;
      OP_ADD: begin
        sum       = {1'b0, acc_q} + {1'b0, operand_q};
        acc_nxt   = sum[DATA_W-1:0];
        carry_nxt = sum[DATA_W];
      end
      OP_SUB: begin
        acc_nxt   = acc_q - operand_q;
        carry_nxt = (acc_q < operand_q);
      end
      OP_AND: acc_nxt = acc_q & operand_q;
      OP_OR:  acc_nxt = acc_q | operand_q;
      OP_XOR: acc_nxt = acc_q ^ operand_q;
      OP_SHL: begin
        carry_nxt = acc_q[DATA_W-1];
        acc_nxt   = acc_q << 1;
      end
      OP_SHR: begin
        carry_nxt = acc_q[0];
        acc_nxt   = acc_q >> 1;
      end
      OP_ADC: begin
        sum       = {1'b0, acc_q} + {1'b0, operand_q} + {{DATA_W{1'b0}}, carry_q};
        acc_nxt   = sum[DATA_W-1:0];
        carry_nxt = sum[DATA_W];
      end
      default: begin
        acc_nxt   = acc_q;
        carry_nxt = carry_q;
      end
    endcase
  end

  // Datapath registers. Accumulator/carry only commit at the end of EXEC,
  // so an asynchronous reset before then discards the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      reg_q     <= '0;
      imm_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          op_q  <= opcode;
          reg_q <= reg_sel;
          imm_q <= imm;
        end
        READ: operand_q <= rf_read_data;
        EXEC: begin
          acc_q   <= acc_nxt;
          carry_q <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
